dct_transpose_8x8: RTL and testbench
====================================

# dct_transpose_8x8

Ping-pong transposition buffer placed directly downstream of `dct8puntos`. It consumes one 8-point first-stage DCT result per cycle on `y0..y7`, stores eight such rows, and re-emits the block column by column on `c0..c7`. This feeds the second 1-D DCT pass of the 2-D 8x8 HEVC transform. Two banks allow one block to be written while the previous block is read, so streaming is continuous.

## Interface
- `WIDTH`, 19: bit width of each coefficient, matching the `dct8puntos` outputs (two's complement).
- `SHIFT`, 2: rounding right-shift amount; used only when `TRANSPOSE_SCALE_EN` is defined; must be ≥1.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `load` input 1: row valid; the row on `y0..y7` is captured when `load=1` and `busy=0`.
- `y0..y7` input WIDTH each: one transformed row; `yk` is row element k.
- `stall` input 1: downstream hold; when 1, outputs freeze and the read pointer does not advance.
- `valid` output 1: `c0..c7` carry a column.
- `last` output 1: qualifies column 7 of a block; only meaningful with `valid=1`.
- `c0..c7` output WIDTH each: one column; `ck` is the element from row k.
- `busy` output 1: the write bank is occupied; upstream must not assert `load`.
- `ovf` output 1: sticky flag; set when `load=1` while `busy=1`; cleared only by `rst`.

## Operation
- Storage: two banks A and B, each an 8x8 array of WIDTH-bit words, with per-bank `full` flags, a write select `wsel`, a read select `rsel`, a 3-bit `wr_row` and a 3-bit `rd_col`.
- Write side:
  - When `load & ~busy`, write `y0..y7` into `bank[wsel][wr_row][0..7]` and increment `wr_row`.
  - On the write with `wr_row=7`: set `full[wsel]`, toggle `wsel`, wrap `wr_row` to 0.
- `busy` is combinational and equals `full[wsel]`.
- `load` while `busy=1`: the row is dropped, `ovf` is set, and no pointer changes.
- Read side:
  - When `~stall & full[rsel]`, register `ck <= bank[rsel][k][rd_col]`, `valid<=1`, `last<=(rd_col==7)`, and increment `rd_col`.
  - On `rd_col=7`: clear `full[rsel]`, toggle `rsel`, wrap `rd_col`.
  - When `~stall & ~full[rsel]`: `valid<=0` and `last<=0`; `ck` keeps its last value.
  - When `stall=1`: `valid`, `last` and `c0..c7` hold.
- Simultaneous events:
  - A bank's `full` flag can be set by the writer and cleared by the reader on the same edge only for different banks; both updates take effect.
  - A bank freed by the reader on edge E can be written from edge E+1.
- Reset: `valid`, `last`, `ovf`, `c0..c7` = 0; `full`=00; `wsel=rsel=A`; `wr_row=rd_col=0`.
  - Bank contents are not reset.
  - Reset mid-block discards the partial block and any unread block.

## Timing
- The 8th row is captured on edge E. Column 0 is visible after edge E+1, and columns 1..7 follow on consecutive edges if no stall occurs.
- Row-to-column latency: 1 cycle from `full` to first `valid`, 9 cycles from the first row.
- With `stall=0` and back-to-back `load`, throughput is 1 row/cycle in and 1 column/cycle out. `busy` never asserts.
- `busy` rises the cycle after the write bank's 8th row only if the reader has not yet freed the other bank.

## Configuration
- `TRANSPOSE_SCALE_EN` defined: each word is stored as `(y + 2^(SHIFT-1)) >>> SHIFT` (arithmetic shift, computed at WIDTH+1 bits), then sign-extended back to WIDTH. This implements the HEVC first-stage rounding.
- `TRANSPOSE_SCALE_EN` undefined: words are stored unmodified. `SHIFT` is ignored.

## Structure
- Shared package `dct_pkg`: `DCT_N=8`, `WIDTH_X=9`, `WIDTH_Y=19`, `DCT_SHIFT1=2`, and a coefficient typedef `coef_t` (signed `[WIDTH_Y-1:0]`).
- One sub-module, `transpose_bank`: an 8x8 register array with one row-write port (`we`, `row`, 8 words) and one column-read port (`col` → 8 words). It is instantiated twice; control and output registers live in the top level.

## Test plan
- Single block: load rows r=0..7 with `yk=8r+k` on 8 consecutive cycles, `stall=0` → columns c=0..7 give `ck=8k+c` on 8 consecutive cycles. First `valid` is 1 cycle after the 8th row's edge; `last` is high on c=7 only.
- Streaming: 16 back-to-back rows (two blocks, second block offset +100) → 16 consecutive `valid` cycles with correct transposes. `busy` and `ovf` stay 0.
- Stall and overflow:
  - Hold `stall=1` for 10 cycles starting at column 2 of block 0, while block 1 is loaded and a third block's first row is offered.
  - Outputs must freeze at column 2, `busy=1` after block 1 completes, and the offered row is dropped with `ovf=1`.
  - After release, columns 3..7 of block 0 are correct.
- Partial block: load 5 rows and stop → `valid` stays 0. Loading 3 more rows then completes the block correctly.
- Scale (`TRANSPOSE_SCALE_EN`, SHIFT=2): inputs 6, -6, 1, -2 → outputs 2, -1, 0, 0.
- Reset mid-operation:
  - Assert `rst` asynchronously during column 4 → all outputs and flags are 0 immediately.
  - A fresh block loaded after release emits correctly starting at column 0.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants and types for the 8x8 HEVC DCT datapath.
// Bank select encoding and its toggle helper live here too.
package dct_pkg;

    localparam int DCT_N      = 8;
    localparam int WIDTH_X    = 9;
    localparam int WIDTH_Y    = 19;
    localparam int DCT_SHIFT1 = 2;

    typedef logic signed [WIDTH_Y-1:0] coef_t;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_e;

    function automatic bank_e bank_flip(input bank_e b);
        return (b == BANK_A) ? BANK_B : BANK_A;
    endfunction

endpackage

// File: rtl/transpose_bank.sv
// 8x8 word array: one row-write port, one combinational column-read port.
// Contents are deliberately not reset.
module transpose_bank
    import dct_pkg::*;
#(
    parameter int WIDTH = WIDTH_Y
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [2:0]       row_i,
    input  logic [WIDTH-1:0] d_i [DCT_N],
    input  logic [2:0]       col_i,
    output logic [WIDTH-1:0] q_o [DCT_N]
);

    logic [WIDTH-1:0] mem_q [DCT_N][DCT_N];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < DCT_N; k++) begin
                mem_q[row_i][k] <= d_i[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DCT_N; k++) begin
            q_o[k] = mem_q[k][col_i];
        end
    end

endmodule

// File: rtl/dct_transpose_8x8.sv
// Ping-pong 8x8 transpose buffer: rows in, columns out, two banks.
// Optional store-side rounding shift enabled by TRANSPOSE_SCALE_EN.
module dct_transpose_8x8
    import dct_pkg::*;
#(
    parameter int WIDTH = WIDTH_Y,
    parameter int SHIFT = DCT_SHIFT1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] y2,
    input  logic [WIDTH-1:0] y3,
    input  logic [WIDTH-1:0] y4,
    input  logic [WIDTH-1:0] y5,
    input  logic [WIDTH-1:0] y6,
    input  logic [WIDTH-1:0] y7,
    input  logic             stall,
    output logic             valid,
    output logic             last,
    output logic [WIDTH-1:0] c0,
    output logic [WIDTH-1:0] c1,
    output logic [WIDTH-1:0] c2,
    output logic [WIDTH-1:0] c3,
    output logic [WIDTH-1:0] c4,
    output logic [WIDTH-1:0] c5,
    output logic [WIDTH-1:0] c6,
    output logic [WIDTH-1:0] c7,
    output logic             busy,
    output logic             ovf
);

    if (SHIFT < 1) begin : g_shift_chk
        $error("SHIFT must be >= 1");
    end

    bank_e            wsel_q, wsel_d, rsel_q, rsel_d;
    logic [1:0]       full_q, full_d;
    logic [2:0]       wr_row_q, wr_row_d, rd_col_q, rd_col_d;
    logic             valid_q, valid_d, last_q, last_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] c_q [DCT_N];
    logic [WIDTH-1:0] c_d [DCT_N];
    logic [WIDTH-1:0] y_w [DCT_N];
    logic [WIDTH-1:0] st_w [DCT_N];
    logic [WIDTH-1:0] qa_w [DCT_N];
    logic [WIDTH-1:0] qb_w [DCT_N];
    logic             wr_en, rd_en;

    assign y_w = '{y0, y1, y2, y3, y4, y5, y6, y7};

`ifdef TRANSPOSE_SCALE_EN
    localparam logic signed [WIDTH:0] RND = (WIDTH+1)'(1) << (SHIFT - 1);
`endif

    for (genvar k = 0; k < DCT_N; k++) begin : g_store
`ifdef TRANSPOSE_SCALE_EN
        // One extra bit so the rounding add cannot wrap before the shift.
        logic signed [WIDTH:0] sum_w;
        assign sum_w   = $signed({y_w[k][WIDTH-1], y_w[k]}) + RND;
        assign st_w[k] = WIDTH'(sum_w >>> SHIFT);
`else
        assign st_w[k] = y_w[k];
`endif
    end

    assign busy  = full_q[wsel_q];
    assign wr_en = load & ~busy;
    assign rd_en = ~stall & full_q[rsel_q];

    transpose_bank #(.WIDTH(WIDTH)) u_bank_a (
        .clk_i (clk),
        .we_i  (wr_en & (wsel_q == BANK_A)),
        .row_i (wr_row_q),
        .d_i   (st_w),
        .col_i (rd_col_q),
        .q_o   (qa_w)
    );

    transpose_bank #(.WIDTH(WIDTH)) u_bank_b (
        .clk_i (clk),
        .we_i  (wr_en & (wsel_q == BANK_B)),
        .row_i (wr_row_q),
        .d_i   (st_w),
        .col_i (rd_col_q),
        .q_o   (qb_w)
    );

    always_comb begin
        wsel_d   = wsel_q;
        rsel_d   = rsel_q;
        full_d   = full_q;
        wr_row_d = wr_row_q;
        rd_col_d = rd_col_q;
        valid_d  = valid_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        c_d      = c_q;

        if (load & busy) begin
            ovf_d = 1'b1;
        end else if (wr_en) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = bank_flip(wsel_q);
            end
        end

        // Writer and reader always target different banks here.
        if (rd_en) begin
            for (int k = 0; k < DCT_N; k++) begin
                c_d[k] = (rsel_q == BANK_B) ? qb_w[k] : qa_w[k];
            end
            valid_d  = 1'b1;
            last_d   = (rd_col_q == 3'd7);
            rd_col_d = rd_col_q + 3'd1;
            if (rd_col_q == 3'd7) begin
                full_d[rsel_q] = 1'b0;
                rsel_d         = bank_flip(rsel_q);
            end
        end else if (!stall) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wsel_q   <= BANK_A;
            rsel_q   <= BANK_A;
            full_q   <= 2'b00;
            wr_row_q <= 3'd0;
            rd_col_q <= 3'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
            c_q      <= '{default: '0};
        end else begin
            wsel_q   <= wsel_d;
            rsel_q   <= rsel_d;
            full_q   <= full_d;
            wr_row_q <= wr_row_d;
            rd_col_q <= rd_col_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            c_q      <= c_d;
        end
    end

    assign valid = valid_q;
    assign last  = last_q;
    assign ovf   = ovf_q;
    assign c0    = c_q[0];
    assign c1    = c_q[1];
    assign c2    = c_q[2];
    assign c3    = c_q[3];
    assign c4    = c_q[4];
    assign c5    = c_q[5];
    assign c6    = c_q[6];
    assign c7    = c_q[7];

endmodule

// File: tb/tb_dct_transpose_8x8.sv
// Directed bench for the ping-pong 8x8 transpose buffer.
module tb_dct_transpose_8x8;

    localparam int W  = 19;
    localparam int SH = 2;

    logic         clk = 1'b0;
    logic         rst, load, stall;
    logic [W-1:0] y [8];
    logic [W-1:0] c [8];
    logic         valid, last, busy, ovf;
    int           checks = 0;
    int           failures = 0;

    dct_transpose_8x8 dut (
        .clk(clk), .rst(rst), .load(load),
        .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]),
        .y4(y[4]), .y5(y[5]), .y6(y[6]), .y7(y[7]),
        .stall(stall), .valid(valid), .last(last),
        .c0(c[0]), .c1(c[1]), .c2(c[2]), .c3(c[3]),
        .c4(c[4]), .c5(c[5]), .c6(c[6]), .c7(c[7]),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] scl(input int v);
`ifdef TRANSPOSE_SCALE_EN
        return W'((v + (1 << (SH - 1))) >>> SH);
`else
        return W'(v);
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_row(input int base, input int r);
        load = 1'b1;
        for (int k = 0; k < 8; k++) y[k] = W'(base + 8 * r + k);
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; stall = 1'b0;
        for (int k = 0; k < 8; k++) y[k] = '0;
        tick(); tick();
        checks++;
        if ({valid, last, busy, ovf} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got %b exp 0000", {valid, last, busy, ovf});
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (c[k] !== '0) begin
                failures++;
                $display("FAIL reset_c%0d got %0d exp 0", k, c[k]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_block;
        for (int t = 0; t < 17; t++) begin
            if (t < 8) drive_row(0, t);
            else load = 1'b0;
            tick();
            checks++;
            if (valid !== (t >= 8 && t < 16) || last !== (t == 15) || busy !== 1'b0) begin
                failures++;
                $display("FAIL single_ctl t=%0d got v%b l%b b%b", t, valid, last, busy);
            end
            if (t >= 8 && t < 16) begin
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (c[k] !== scl(8 * k + t - 8)) begin
                        failures++;
                        $display("FAIL single_c%0d col%0d got %0d exp %0d",
                                 k, t - 8, c[k], scl(8 * k + t - 8));
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int base, col;
        for (int t = 0; t < 25; t++) begin
            if (t < 16) drive_row((t < 8) ? 0 : 100, t % 8);
            else load = 1'b0;
            tick();
            checks++;
            if (valid !== (t >= 8 && t < 24) || last !== (t == 15 || t == 23)
                || busy !== 1'b0 || ovf !== 1'b0) begin
                failures++;
                $display("FAIL stream_ctl t=%0d got v%b l%b b%b o%b", t, valid, last, busy, ovf);
            end
            if (t >= 8 && t < 24) begin
                base = (t < 16) ? 0 : 100;
                col  = (t - 8) % 8;
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (c[k] !== scl(base + 8 * k + col)) begin
                        failures++;
                        $display("FAIL stream_c%0d t=%0d got %0d exp %0d",
                                 k, t, c[k], scl(base + 8 * k + col));
                    end
                end
            end
        end
    endtask

    task automatic test_partial;
        for (int t = 0; t < 23; t++) begin
            if (t < 5) drive_row(400, t);
            else if (t >= 11 && t < 14) drive_row(400, t - 6);
            else load = 1'b0;
            tick();
            checks++;
            if (valid !== (t >= 14 && t < 22) || last !== (t == 21)) begin
                failures++;
                $display("FAIL partial_ctl t=%0d got v%b l%b", t, valid, last);
            end
            if (t >= 14 && t < 22) begin
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (c[k] !== scl(400 + 8 * k + t - 14)) begin
                        failures++;
                        $display("FAIL partial_c%0d t=%0d got %0d exp %0d",
                                 k, t, c[k], scl(400 + 8 * k + t - 14));
                    end
                end
            end
        end
    endtask

    task automatic test_stall_ovf;
        int exp_c [8];
        logic exp_v, exp_l;
        for (int t = 0; t < 36; t++) begin
            if (t < 8) drive_row(200, t);
            else if (t < 16) drive_row(300, t - 8);
            else if (t == 16) drive_row(999, 0);
            else load = 1'b0;
            stall = (t >= 11 && t <= 20);
            tick();
            exp_v = 1'b1; exp_l = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (t >= 8 && t <= 10) exp_c[k] = 200 + 8 * k + t - 8;
                else if (t >= 11 && t <= 20) exp_c[k] = 200 + 8 * k + 2;
                else if (t >= 21 && t <= 25) exp_c[k] = 200 + 8 * k + t - 18;
                else if (t >= 26 && t <= 33) exp_c[k] = 300 + 8 * k + t - 26;
                else exp_c[k] = 0;
            end
            if (t < 8 || t > 33) exp_v = 1'b0;
            if (t == 25 || t == 33) exp_l = 1'b1;
            checks++;
            if (valid !== exp_v || last !== exp_l) begin
                failures++;
                $display("FAIL stall_ctl t=%0d got v%b l%b exp v%b l%b",
                         t, valid, last, exp_v, exp_l);
            end
            checks++;
            if (busy !== (t >= 15 && t <= 24) || ovf !== (t >= 16)) begin
                failures++;
                $display("FAIL stall_flags t=%0d got b%b o%b", t, busy, ovf);
            end
            if (exp_v) begin
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (c[k] !== scl(exp_c[k])) begin
                        failures++;
                        $display("FAIL stall_c%0d t=%0d got %0d exp %0d",
                                 k, t, c[k], scl(exp_c[k]));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int t = 0; t < 13; t++) begin
            if (t < 8) drive_row(500, t);
            else drive_row(700, t - 8);
            tick();
        end
        checks++;
        if (valid !== 1'b1 || ovf !== 1'b1 || c[1] !== scl(500 + 8 + 4)) begin
            failures++;
            $display("FAIL rstmid_pre got v%b o%b c1=%0d", valid, ovf, c[1]);
        end
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid, last, busy, ovf} !== 4'b0) begin
            failures++;
            $display("FAIL rstmid_flags got %b exp 0000", {valid, last, busy, ovf});
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (c[k] !== '0) begin
                failures++;
                $display("FAIL rstmid_c%0d got %0d exp 0", k, c[k]);
            end
        end
        tick();
        rst = 1'b0;
        for (int t = 0; t < 17; t++) begin
            if (t < 8) drive_row(600, t);
            else load = 1'b0;
            tick();
            checks++;
            if (valid !== (t >= 8 && t < 16) || last !== (t == 15)) begin
                failures++;
                $display("FAIL rstmid_ctl t=%0d got v%b l%b", t, valid, last);
            end
            if (t >= 8 && t < 16) begin
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (c[k] !== scl(600 + 8 * k + t - 8)) begin
                        failures++;
                        $display("FAIL rstmid_c%0d t=%0d got %0d exp %0d",
                                 k, t, c[k], scl(600 + 8 * k + t - 8));
                    end
                end
            end
        end
    endtask

`ifdef TRANSPOSE_SCALE_EN
    task automatic test_scale;
        int in_v [4] = '{6, -6, 1, -2};
        int ex_v [4] = '{2, -1, 0, 0};
        for (int t = 0; t < 12; t++) begin
            load = (t < 8);
            for (int k = 0; k < 8; k++) y[k] = '0;
            if (t == 0) for (int k = 0; k < 4; k++) y[k] = W'(in_v[k]);
            tick();
            if (t >= 8) begin
                checks++;
                if (valid !== 1'b1 || c[0] !== W'(ex_v[t - 8]) || c[1] !== '0) begin
                    failures++;
                    $display("FAIL scale col%0d got v%b c0=%0d exp %0d",
                             t - 8, valid, $signed(c[0]), ex_v[t - 8]);
                end
            end
        end
        load = 1'b0;
        for (int t = 0; t < 5; t++) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_partial();
        test_stall_ovf();
        test_reset_mid();
`ifdef TRANSPOSE_SCALE_EN
        test_scale();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
